// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the unified-memory port arbiter:
//   - default address/data widths
//   - arbiter FSM state encoding (2 bits)
//   - requester select codes (fetch / load-store)
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

   localparam int unsigned ARB_AW = 32;
   localparam int unsigned ARB_DW = 32;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_RESP   = 2'd2
   } arb_state_e;

   typedef enum logic {
      SEL_I = 1'b0,
      SEL_D = 1'b1
   } arb_sel_e;

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch port (i_*), the load/store port (d_*), the memory port
// (mem_*) and the busy flag of the arbiter.
//   modport master : used by the arbiter (it drives the memory bus and answers
//                    both requesters)
//   modport slave  : used by the surrounding core / memory model
// Parameters: AW address width, DW data width (byte enables are DW/8 bits).
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   // fetch port
   logic              i_req;
   logic [AW-1:0]     i_addr;
   logic              i_gnt;
   logic              i_valid;
   logic [DW-1:0]     i_rdata;
   logic              i_err;
   // load/store port
   logic              d_req;
   logic              d_we;
   logic [AW-1:0]     d_addr;
   logic [DW-1:0]     d_wdata;
   logic [DW/8-1:0]   d_be;
   logic              d_gnt;
   logic              d_valid;
   logic [DW-1:0]     d_rdata;
   logic              d_err;
   // memory port
   logic              mem_req;
   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic [DW/8-1:0]   mem_be;
   logic              mem_ready;
   logic [DW-1:0]     mem_rdata;
   // stall hint for the core
   logic              busy;

   modport master (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
      output i_gnt, i_valid, i_rdata, i_err, d_gnt, d_valid, d_rdata, d_err,
             mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy
   );

   modport slave (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
      input  i_gnt, i_valid, i_rdata, i_err, d_gnt, d_valid, d_rdata, d_err,
             mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy
   );

endinterface : mem_port_arbiter_if

// File: rtl/mem_timeout_cnt.sv
// -----------------------------------------------------------------------------
// mem_timeout_cnt
// Counts memory wait cycles for the arbiter's optional timeout abort
// (only instantiated when MEM_TIMEOUT_EN is defined).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear_i     restart at zero (entry into ACCESS)
//   en_i        one more ACCESS cycle without mem_ready
//   expired_o   count has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module mem_timeout_cnt #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i && !expired_o) begin
         // Holds at the limit; the arbiter leaves ACCESS on that cycle anyway.
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : mem_timeout_cnt

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the CPU's single-port unified memory between instruction fetch (I)
// and load/store (D). One access at a time: IDLE (grant + register payload)
// -> ACCESS (mem_req held until mem_ready) -> RESP (one-cycle valid pulse).
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset; all outputs drop to 0 at once
//   bus     mem_port_arbiter_if.master: i_* fetch port, d_* load/store port,
//           mem_* memory port, busy stall flag
// Parameters:
//   AW, DW      address / data width
//   DATA_PRIO   1: D wins simultaneous requests; 0: round-robin
//   TIMEOUT     ACCESS cycles before abort (MEM_TIMEOUT_EN only)
// Configuration macro:
//   MEM_TIMEOUT_EN  when defined, an access with no mem_ready for TIMEOUT
//                   cycles is aborted and answered with *_valid + *_err.
//                   When undefined, ACCESS waits forever and *_err are 0.
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned AW        = ARB_AW,
   parameter int unsigned DW        = ARB_DW,
   parameter int unsigned DATA_PRIO = 1,
   parameter int unsigned TIMEOUT   = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   mem_port_arbiter_if.master  bus
);

   localparam int unsigned BW = DW / 8;

   if (((DW % 8) != 0) || (TIMEOUT < 2)) begin : g_cfg_check
      $error("mem_port_arbiter: DW must be a multiple of 8 and TIMEOUT at least 2");
   end

   arb_state_e        state_q, state_d;
   arb_sel_e          sel_q, sel_d;
   arb_sel_e          rr_last_q, rr_last_d;
   logic              mem_we_q, mem_we_d;
   logic [AW-1:0]     mem_addr_q, mem_addr_d;
   logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
   logic [BW-1:0]     mem_be_q, mem_be_d;
   logic [DW-1:0]     i_rdata_q, i_rdata_d;
   logic [DW-1:0]     d_rdata_q, d_rdata_d;

   logic              grant_i, grant_d;
   logic              pick_d;
   logic              timeout_hit;

   // ---------------------------------------------------------------------------
   // Next-state / grant logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no branch can
      // leave one unassigned and infer a latch.
      state_d     = state_q;
      sel_d       = sel_q;
      rr_last_d   = rr_last_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      grant_i     = 1'b0;
      grant_d     = 1'b0;

      // D wins if it is alone, if data has priority, or if I was served last.
      pick_d = bus.d_req && (!bus.i_req || (DATA_PRIO != 0) || (rr_last_q == SEL_I));

      unique case (state_q)
         ARB_IDLE: begin
            // rst_n gating keeps the combinational grants at 0 during reset.
            if (rst_n && (bus.i_req || bus.d_req)) begin
               state_d = ARB_ACCESS;
               if (pick_d) begin
                  grant_d     = 1'b1;
                  sel_d       = SEL_D;
                  rr_last_d   = SEL_D;
                  mem_we_d    = bus.d_we;
                  mem_addr_d  = bus.d_addr;
                  mem_wdata_d = bus.d_wdata;
                  mem_be_d    = bus.d_be;
               end else begin
                  grant_i     = 1'b1;
                  sel_d       = SEL_I;
                  rr_last_d   = SEL_I;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = bus.i_addr;
                  mem_wdata_d = '0;
                  mem_be_d    = '1;
               end
            end
         end

         ARB_ACCESS: begin
            if (bus.mem_ready) begin
               // Stores leave d_rdata untouched.
               if (sel_q == SEL_I) begin
                  i_rdata_d = bus.mem_rdata;
               end else if (!mem_we_q) begin
                  d_rdata_d = bus.mem_rdata;
               end
               state_d = ARB_RESP;
            end else if (timeout_hit) begin
               state_d = ARB_RESP;
            end
         end

         ARB_RESP: begin
            state_d = ARB_IDLE;
         end

         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State and payload registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ARB_IDLE;
         sel_q       <= SEL_I;
         rr_last_q   <= SEL_I;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         // NOTE: the read-data holding registers are ordinary flops, not a
         // memory array, so they are reset along with the rest of the state.
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge
         // values regardless of statement order.
         state_q     <= state_d;
         sel_q       <= sel_d;
         rr_last_q   <= rr_last_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Optional timeout abort
   // ---------------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
   logic expired;
   logic err_q;

   mem_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (grant_i || grant_d),
      .en_i      ((state_q == ARB_ACCESS) && !bus.mem_ready),
      .expired_o (expired)
   );

   // mem_ready on the limit cycle wins: that access completes normally.
   assign timeout_hit = (state_q == ARB_ACCESS) && !bus.mem_ready && expired;

   // Set only on the abort edge, so it is high exactly during the RESP cycle
   // that follows an abort.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= timeout_hit;
      end
   end

   assign bus.i_err = bus.i_valid && err_q;
   assign bus.d_err = bus.d_valid && err_q;
`else
   assign timeout_hit = 1'b0;
   assign bus.i_err   = 1'b0;
   assign bus.d_err   = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.i_gnt     = grant_i;
   assign bus.d_gnt     = grant_d;
   assign bus.i_valid   = (state_q == ARB_RESP) && (sel_q == SEL_I);
   assign bus.d_valid   = (state_q == ARB_RESP) && (sel_q == SEL_D);
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.mem_req   = (state_q == ARB_ACCESS);
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_be    = mem_be_q;
   assign bus.busy      = rst_n && ((state_q != ARB_IDLE) || bus.i_req || bus.d_req);

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Two arbiters side by side: u_prio (DATA_PRIO=1) and u_rr (DATA_PRIO=0), each
// with a small memory responder that raises mem_ready after a programmable
// number of mem_req cycles (or never). Inputs change #1 after the rising edge;
// outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mem_port_arbiter;

   logic clk;
   logic rst_n;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter_if #(.AW(32), .DW(32)) bp ();
   mem_port_arbiter_if #(.AW(32), .DW(32)) br ();

   mem_port_arbiter #(.AW(32), .DW(32), .DATA_PRIO(1), .TIMEOUT(16)) u_prio (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bp)
   );

   mem_port_arbiter #(.AW(32), .DW(32), .DATA_PRIO(0), .TIMEOUT(16)) u_rr (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (br)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Responder settings for u_prio; u_rr always answers with zero wait.
   int   p_wait  = 0;
   logic p_never = 1'b0;

   initial begin : prio_mem
      int cnt;
      cnt = 0;
      bp.mem_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!bp.mem_req) begin
            cnt = 0;
            bp.mem_ready = 1'b0;
         end else begin
            bp.mem_ready = !p_never && (cnt >= p_wait);
            cnt++;
         end
      end
   end

   initial begin : rr_mem
      br.mem_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         br.mem_ready = br.mem_req;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        i_req;
      logic        d_req;
      logic        d_we;
      logic [31:0] i_addr;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic [3:0]  d_be;
      logic [31:0] rdata;
      logic        exp_d;
      logic        exp_we;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_i_rdata;
      logic [31:0] exp_d_rdata;
   } vec_t;

   vec_t vecs[5];

   initial begin : main
      logic [1:0] rr_exp [4];

      // fetch 0x100 -> I; load 0x200 -> D; store with be 0011 (rdata unchanged);
      // simultaneous -> D wins; fetch 0x104 -> I
      vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0,   32'h0,        4'h0,    32'h12345678,
                  1'b0, 1'b0, 32'h100, 4'hF,    32'h0,        32'h12345678, 32'h0};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h200, 32'h0,        4'hF,    32'hDEADBEEF,
                  1'b1, 1'b0, 32'h200, 4'hF,    32'h0,        32'h12345678, 32'hDEADBEEF};
      vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h40,  32'hA5A5A5A5, 4'b0011, 32'h11111111,
                  1'b1, 1'b1, 32'h40,  4'b0011, 32'hA5A5A5A5, 32'h12345678, 32'hDEADBEEF};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h180, 32'h300, 32'h0,        4'hF,    32'hCAFEF00D,
                  1'b1, 1'b0, 32'h300, 4'hF,    32'h0,        32'h12345678, 32'hCAFEF00D};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h104, 32'h0,   32'h0,        4'h0,    32'h0BADF00D,
                  1'b0, 1'b0, 32'h104, 4'hF,    32'h0,        32'h0BADF00D, 32'hCAFEF00D};

      // {i_gnt, d_gnt}: D first because rr_last resets to I
      rr_exp[0] = 2'b01;
      rr_exp[1] = 2'b10;
      rr_exp[2] = 2'b01;
      rr_exp[3] = 2'b10;

      bp.i_req = 1'b0; bp.i_addr = '0; bp.d_req = 1'b0; bp.d_we = 1'b0;
      bp.d_addr = '0; bp.d_wdata = '0; bp.d_be = '0; bp.mem_rdata = '0;
      br.i_req = 1'b0; br.i_addr = '0; br.d_req = 1'b0; br.d_we = 1'b0;
      br.d_addr = '0; br.d_wdata = '0; br.d_be = '0; br.mem_rdata = '0;

      // ---------------- reset state ----------------
      rst_n = 1'b0;
      repeat (2) next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_mem_req", 32'(bp.mem_req), 32'd0);
      check("rst_valid",   32'({bp.i_valid, bp.d_valid}), 32'd0);
      check("rst_i_rdata", bp.i_rdata, 32'h0);
      check("rst_d_rdata", bp.d_rdata, 32'h0);
      check("rst_busy",    32'(bp.busy), 32'd0);
      check("rst_mem_be",  32'(bp.mem_be), 32'd0);
      next_cycle();

      // ---------------- table: single transactions, zero-wait memory --------
      for (int k = 0; k < 5; k++) begin
         bp.i_req = vecs[k].i_req;   bp.d_req = vecs[k].d_req;   bp.d_we = vecs[k].d_we;
         bp.i_addr = vecs[k].i_addr; bp.d_addr = vecs[k].d_addr;
         bp.d_wdata = vecs[k].d_wdata; bp.d_be = vecs[k].d_be;
         bp.mem_rdata = vecs[k].rdata;
         @(negedge clk);
         check($sformatf("v%0d_gnt", k), 32'({bp.i_gnt, bp.d_gnt}),
               vecs[k].exp_d ? 32'd1 : 32'd2);
         check($sformatf("v%0d_busy", k), 32'(bp.busy), 32'd1);
         next_cycle();
         @(negedge clk);
         check($sformatf("v%0d_mem_req", k), 32'(bp.mem_req), 32'd1);
         check($sformatf("v%0d_mem_we", k), 32'(bp.mem_we), 32'(vecs[k].exp_we));
         check($sformatf("v%0d_mem_addr", k), bp.mem_addr, vecs[k].exp_addr);
         check($sformatf("v%0d_mem_be", k), 32'(bp.mem_be), 32'(vecs[k].exp_be));
         if (vecs[k].exp_we) begin
            check($sformatf("v%0d_mem_wdata", k), bp.mem_wdata, vecs[k].exp_wdata);
         end
         next_cycle();
         @(negedge clk);
         check($sformatf("v%0d_valid", k), 32'({bp.i_valid, bp.d_valid}),
               vecs[k].exp_d ? 32'd1 : 32'd2);
         check($sformatf("v%0d_mem_req_off", k), 32'(bp.mem_req), 32'd0);
         check($sformatf("v%0d_i_rdata", k), bp.i_rdata, vecs[k].exp_i_rdata);
         check($sformatf("v%0d_d_rdata", k), bp.d_rdata, vecs[k].exp_d_rdata);
         check($sformatf("v%0d_err", k), 32'({bp.i_err, bp.d_err}), 32'd0);
         next_cycle();
         bp.i_req = 1'b0;
         bp.d_req = 1'b0;
         #1;
         check($sformatf("v%0d_idle_busy", k), 32'(bp.busy), 32'd0);
      end

      // ---------------- D priority: store first, I granted at c3 ------------
      bp.i_req = 1'b1; bp.i_addr = 32'h108;
      bp.d_req = 1'b1; bp.d_we = 1'b1; bp.d_addr = 32'h40;
      bp.d_wdata = 32'hA5A5A5A5; bp.d_be = 4'b0011;
      bp.mem_rdata = 32'h77665544;
      @(negedge clk);
      check("prio_c0_gnt", 32'({bp.i_gnt, bp.d_gnt}), 32'd1);
      next_cycle();
      @(negedge clk);
      check("prio_c1_mem_be",    32'(bp.mem_be), 32'h3);
      check("prio_c1_mem_wdata", bp.mem_wdata, 32'hA5A5A5A5);
      next_cycle();
      @(negedge clk);
      check("prio_c2_d_valid", 32'({bp.i_valid, bp.d_valid}), 32'd1);
      check("prio_c2_d_rdata", bp.d_rdata, 32'hCAFEF00D);
      next_cycle();
      bp.d_req = 1'b0;
      @(negedge clk);
      check("prio_c3_i_gnt", 32'({bp.i_gnt, bp.d_gnt}), 32'd2);
      next_cycle();
      @(negedge clk);
      check("prio_c4_mem_addr", bp.mem_addr, 32'h108);
      check("prio_c4_mem_we",   32'(bp.mem_we), 32'd0);
      next_cycle();
      @(negedge clk);
      check("prio_c5_i_valid", 32'({bp.i_valid, bp.d_valid}), 32'd2);
      check("prio_c5_i_rdata", bp.i_rdata, 32'h77665544);
      next_cycle();
      bp.i_req = 1'b0;

      // ---------------- load with mem_ready delayed 5 cycles ----------------
      p_wait = 5;
      bp.d_req = 1'b1; bp.d_we = 1'b0; bp.d_addr = 32'h80; bp.d_be = 4'hF;
      bp.mem_rdata = 32'h99887766;
      @(negedge clk);
      check("wait_gnt", 32'(bp.d_gnt), 32'd1);
      for (int k = 0; k < 6; k++) begin
         next_cycle();
         @(negedge clk);
         check($sformatf("wait_c%0d_mem_req", k + 1), 32'(bp.mem_req), 32'd1);
         check($sformatf("wait_c%0d_mem_addr", k + 1), bp.mem_addr, 32'h80);
         check($sformatf("wait_c%0d_no_valid", k + 1), 32'(bp.d_valid), 32'd0);
      end
      next_cycle();
      @(negedge clk);
      check("wait_c7_d_valid", 32'(bp.d_valid), 32'd1);
      check("wait_c7_mem_req", 32'(bp.mem_req), 32'd0);
      check("wait_c7_d_rdata", bp.d_rdata, 32'h99887766);
      next_cycle();
      bp.d_req = 1'b0;
      p_wait = 0;

      // ---------------- memory never answers --------------------------------
      p_never = 1'b1;
      bp.i_req = 1'b1; bp.i_addr = 32'h500; bp.mem_rdata = 32'h55AA55AA;
      @(negedge clk);
      check("to_gnt", 32'(bp.i_gnt), 32'd1);
`ifdef MEM_TIMEOUT_EN
      for (int k = 0; k < 16; k++) begin
         next_cycle();
         @(negedge clk);
         check($sformatf("to_c%0d_mem_req", k + 1), 32'(bp.mem_req), 32'd1);
         check($sformatf("to_c%0d_no_valid", k + 1), 32'(bp.i_valid), 32'd0);
      end
      next_cycle();
      @(negedge clk);
      check("to_c17_mem_req", 32'(bp.mem_req), 32'd0);
      check("to_c17_valid_err", 32'({bp.i_valid, bp.i_err}), 32'd3);
      check("to_c17_d_err", 32'(bp.d_err), 32'd0);
      check("to_c17_i_rdata", bp.i_rdata, 32'h77665544);
`else
      for (int k = 0; k < 20; k++) begin
         next_cycle();
         @(negedge clk);
         check($sformatf("wait_forever_c%0d_mem_req", k + 1), 32'(bp.mem_req), 32'd1);
         check($sformatf("wait_forever_c%0d_valid", k + 1), 32'({bp.i_valid, bp.i_err}), 32'd0);
      end
      p_never = 1'b0;
      next_cycle();
      @(negedge clk);
      check("late_ready_mem_req", 32'(bp.mem_req), 32'd1);
      next_cycle();
      @(negedge clk);
      check("late_ready_valid_err", 32'({bp.i_valid, bp.i_err}), 32'd2);
      check("late_ready_i_rdata", bp.i_rdata, 32'h55AA55AA);
`endif
      next_cycle();
      bp.i_req = 1'b0;
      p_never = 1'b0;

      // ---------------- round-robin on u_rr, both held high ----------------
      br.i_req = 1'b1; br.i_addr = 32'h1000;
      br.d_req = 1'b1; br.d_we = 1'b0; br.d_addr = 32'h2000; br.d_be = 4'hF;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         check($sformatf("rr%0d_gnt", t), 32'({br.i_gnt, br.d_gnt}), 32'(rr_exp[t]));
         next_cycle();
         @(negedge clk);
         check($sformatf("rr%0d_mem_addr", t), br.mem_addr,
               (rr_exp[t] == 2'b01) ? 32'h2000 : 32'h1000);
         next_cycle();
         @(negedge clk);
         check($sformatf("rr%0d_valid", t), 32'({br.i_valid, br.d_valid}), 32'(rr_exp[t]));
         next_cycle();
      end
      br.i_req = 1'b0;
      br.d_req = 1'b0;

      // ---------------- reset in the middle of ACCESS ----------------------
      p_never = 1'b1;
      bp.i_req = 1'b1; bp.i_addr = 32'h600; bp.mem_rdata = 32'h31415926;
      @(negedge clk);
      check("ra_gnt", 32'(bp.i_gnt), 32'd1);
      next_cycle();
      @(negedge clk);
      check("ra_mem_req_before", 32'(bp.mem_req), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ra_mem_req_async", 32'(bp.mem_req), 32'd0);
      check("ra_gnt_in_reset",  32'(bp.i_gnt), 32'd0);
      check("ra_busy_in_reset", 32'(bp.busy), 32'd0);
      check("ra_i_rdata_reset", bp.i_rdata, 32'h0);
      check("ra_d_rdata_reset", bp.d_rdata, 32'h0);
      check("ra_mem_addr_reset", bp.mem_addr, 32'h0);
      @(negedge clk);
      check("ra_no_valid", 32'({bp.i_valid, bp.d_valid, bp.mem_req}), 32'd0);
      #1;
      rst_n = 1'b1;
      p_never = 1'b0;
      #1;
      check("ra_regrant", 32'(bp.i_gnt), 32'd1);
      next_cycle();
      @(negedge clk);
      check("ra_mem_addr", bp.mem_addr, 32'h600);
      check("ra_mem_req",  32'(bp.mem_req), 32'd1);
      next_cycle();
      @(negedge clk);
      check("ra_i_valid", 32'(bp.i_valid), 32'd1);
      check("ra_i_rdata", bp.i_rdata, 32'h31415926);
      next_cycle();
      bp.i_req = 1'b0;
      repeat (2) next_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mem_port_arbiter
